adder_bist_ctrl: RTL
====================

Name: adder_bist_ctrl

Overview:
Built-in self-test controller placed around the ripple-carry adder under diagnosis.
- Upstream role: drives an exhaustive {A, B, CIN} stimulus sweep into the adder.
- Downstream role: consumes the adder's SUM and compares it against a golden A+B+CIN.
- Reports pass/fail, a mismatch count, the first failing vector and an OR-accumulated bit-error mask that localises the faulty slice.

Parameters:
- WIDTH, 8: operand width; SUM is WIDTH+1 bits.
- SETTLE_CYCLES, 2: cycles allowed for the combinational adder to settle before sampling; must be >= 1.
- CNT_W, 16: width of the mismatch counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begins a run when the FSM is in IDLE or DONE
- stop_on_fail  in  1  sampled at start; if set, the run ends at the first mismatch
- tpg_a  out  WIDTH  stimulus operand A
- tpg_b  out  WIDTH  stimulus operand B
- tpg_cin  out  1  stimulus carry-in
- dut_sum  in  WIDTH+1  adder result
- busy  out  1  run in progress
- done  out  1  run finished; sticky until the next start
- pass  out  1  valid when done=1; high if no mismatch occurred
- fail_count  out  CNT_W  number of mismatching vectors, saturating
- first_fail_vec  out  2*WIDTH+1  {A,B,CIN} of the first mismatch
- first_fail_sum  out  WIDTH+1  dut_sum observed at the first mismatch
- err_mask  out  WIDTH+1  OR over all mismatches of (dut_sum XOR expected)

Behaviour:
- Reset: state IDLE. tpg_a, tpg_b, tpg_cin, busy, done, pass, fail_count, first_fail_vec, first_fail_sum and err_mask are all 0.
- Vector index idx is 2*WIDTH+1 bits.
  - tpg_cin = idx[0]
  - tpg_b = idx[WIDTH:1]
  - tpg_a = idx[2*WIDTH:WIDTH+1]
  - Stimulus outputs are registered directly from idx.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE with start=1:
  - idx <= 0; all result registers cleared; done <= 0; busy <= 1.
  - Latch stop_on_fail.
  - Go to SETTLE with settle_cnt = SETTLE_CYCLES-1.
- SETTLE: decrement settle_cnt each cycle; when it reaches 0, go to CHECK. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK (one cycle):
  - expected = A + B + CIN, computed at WIDTH+1 bits with no truncation.
  - On mismatch:
    - fail_count increments, saturating at all-ones.
    - err_mask |= dut_sum ^ expected.
    - If this is the first mismatch, capture first_fail_vec and first_fail_sum.
  - Exit: if idx is all-ones, or (mismatch and stop_on_fail latched), go to DONE. Otherwise idx <= idx+1, then SETTLE.
- Per-vector cost is SETTLE_CYCLES+1 cycles. A full run is 2^(2*WIDTH+1) * (SETTLE_CYCLES+1) cycles after the start cycle.
- DONE: busy=0, done=1, pass = (fail_count==0). Stimulus holds the last vector.
- start while busy is ignored.
- idx wrap-around never occurs: termination happens on the all-ones index.
- rst_n low at any time, including mid-SETTLE or mid-CHECK, asynchronously returns every output to its reset value. No partial results are retained.

Optional Feature:
ADDER_BIST_MISR_EN
- Defined:
  - Adds output port signature (16 bits, reset 0, cleared at start).
  - Each CHECK cycle: signature <= {signature[14:0],1'b0} ^ (signature[15] ? 16'h1021 : 0) ^ zero-extended dut_sum.
  - Final value is valid when done=1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package adder_bist_pkg contains:
  - state enum (IDLE, SETTLE, CHECK, DONE)
  - MISR_POLY = 16'h1021
  - MISR_W = 16
  - default WIDTH, SETTLE_CYCLES and CNT_W constants
- One sub-module, adder_bist_misr: the signature register, instantiated only under ADDER_BIST_MISR_EN.
- The golden adder stays inline.

Test Plan:
- WIDTH=2, SETTLE_CYCLES=2, correct adder model, start pulse:
  - busy for 96 cycles, then done=1, pass=1, fail_count=0, err_mask=0.
- WIDTH=2, adder with sum[1] stuck-at-0, stop_on_fail=0:
  - fail_count=16, first_fail_vec={A=0,B=1,CIN=1}, first_fail_sum=0, err_mask=3'b010, pass=0.
- Same fault, stop_on_fail=1:
  - done after the 4th CHECK (idx=3), fail_count=1, tpg holds A=0, B=1, CIN=1.
- WIDTH=8, bit-6 slice with sum output inverted:
  - pass=0, err_mask[6]=1, err_mask[5:0]=0.
  - first_fail_vec = {A=0, B=0, CIN=0}, since SUM=64 is observed where 0 is expected.
- Reset mid-run: drop rst_n for 1 cycle during SETTLE at idx=10:
  - all outputs return to 0 and the FSM returns to IDLE.
  - A new start runs the full sweep from idx=0.
- ADDER_BIST_MISR_EN defined, WIDTH=2:
  - signature equals the bench reference model's value for the correct adder.
  - Differs for the stuck-at fault; is 0 after reset.

Source files
------------

// File: rtl/adder_bist_pkg.sv
// rtl/adder_bist_pkg.sv - shared types and constants for the adder BIST controller
//
// Purpose: FSM state encoding, signature register constants and default
//          parameter values used by adder_bist_ctrl and adder_bist_misr.
// Ports:   none (package)
package adder_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } bist_state_e;

  localparam int          MISR_W    = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/adder_bist_misr.sv
// rtl/adder_bist_misr.sv - 16-bit multiple-input signature register
//
// Purpose: compacts every observed adder result into a signature.
//          Used by adder_bist_ctrl only when ADDER_BIST_MISR_EN is defined.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear (run start)
//   en          shift in data this cycle
//   data        zero-extended adder result
//   signature   current signature
module adder_bist_misr
  import adder_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [MISR_W-1:0] data,
  output logic [MISR_W-1:0] signature
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= '0;
    end else if (clr) begin
      signature <= '0;
    end else if (en) begin
      // Shift left with feedback from the MSB, then fold in the new word.
      signature <= {signature[MISR_W-2:0], 1'b0}
                 ^ (signature[MISR_W-1] ? MISR_POLY : '0)
                 ^ data;
    end
  end

endmodule

// File: rtl/adder_bist_ctrl.sv
// rtl/adder_bist_ctrl.sv - exhaustive-sweep BIST controller for a ripple-carry adder
//
// Purpose: sweeps every {A,B,CIN} vector into the adder, waits SETTLE_CYCLES,
//          compares SUM against a golden A+B+CIN and accumulates diagnosis
//          results. Optional macro ADDER_BIST_MISR_EN adds a signature port.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a run (accepted in IDLE or DONE only)
//   stop_on_fail    sampled at start; end run at first mismatch
//   tpg_a/b/cin     stimulus to the adder
//   dut_sum         adder result (WIDTH+1 bits)
//   busy, done      run in progress / run finished (sticky)
//   pass            no mismatch seen (valid with done)
//   fail_count      saturating mismatch count
//   first_fail_vec  {A,B,CIN} of the first mismatch
//   first_fail_sum  dut_sum seen at the first mismatch
//   err_mask        OR of (dut_sum ^ expected) over all mismatches
//   signature       (ADDER_BIST_MISR_EN only) signature of all results
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop_on_fail,
  output logic [WIDTH-1:0]   tpg_a,
  output logic [WIDTH-1:0]   tpg_b,
  output logic               tpg_cin,
  input  logic [WIDTH:0]     dut_sum,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   fail_count,
  output logic [2*WIDTH:0]   first_fail_vec,
  output logic [WIDTH:0]     first_fail_sum,
  output logic [WIDTH:0]     err_mask
`ifdef ADDER_BIST_MISR_EN
  ,
  output logic [MISR_W-1:0]  signature
`endif
);

  localparam int IDX_W = 2*WIDTH + 1;
  localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETTLE_INIT = SC_W'(SETTLE_CYCLES - 1);

  bist_state_e       state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [SC_W-1:0]   settle_cnt, settle_nxt;
  logic              sof_q, sof_nxt;
  logic              busy_nxt, done_nxt, pass_nxt;
  logic [CNT_W-1:0]  fail_count_nxt;
  logic [IDX_W-1:0]  first_fail_vec_nxt;
  logic [WIDTH:0]    first_fail_sum_nxt;
  logic [WIDTH:0]    err_mask_nxt;
  logic [WIDTH:0]    expected;
  logic              mismatch;
  logic              start_run;
  logic              check_en;

  // The stimulus is the index register itself, so it holds the last vector in DONE.
  assign tpg_cin = idx[0];
  assign tpg_b   = idx[WIDTH:1];
  assign tpg_a   = idx[2*WIDTH:WIDTH+1];

  // Golden model, widened so the carry-out is never lost.
  assign expected = {1'b0, idx[2*WIDTH:WIDTH+1]}
                  + {1'b0, idx[WIDTH:1]}
                  + {{WIDTH{1'b0}}, idx[0]};
  assign mismatch = (dut_sum != expected);

  always_comb begin
    state_nxt          = state;
    idx_nxt            = idx;
    settle_nxt         = settle_cnt;
    sof_nxt            = sof_q;
    busy_nxt           = busy;
    done_nxt           = done;
    pass_nxt           = pass;
    fail_count_nxt     = fail_count;
    first_fail_vec_nxt = first_fail_vec;
    first_fail_sum_nxt = first_fail_sum;
    err_mask_nxt       = err_mask;
    start_run          = 1'b0;
    check_en           = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt          = SETTLE;
          idx_nxt            = '0;
          settle_nxt         = SETTLE_INIT;
          sof_nxt            = stop_on_fail;
          busy_nxt           = 1'b1;
          done_nxt           = 1'b0;
          pass_nxt           = 1'b0;
          fail_count_nxt     = '0;
          first_fail_vec_nxt = '0;
          first_fail_sum_nxt = '0;
          err_mask_nxt       = '0;
          start_run          = 1'b1;
        end
      end

      SETTLE: begin
        if (settle_cnt == '0) begin
          state_nxt = CHECK;
        end else begin
          settle_nxt = settle_cnt - 1'b1;
        end
      end

      CHECK: begin
        check_en = 1'b1;
        if (mismatch) begin
          if (fail_count != '1) begin
            fail_count_nxt = fail_count + 1'b1;
          end
          err_mask_nxt = err_mask | (dut_sum ^ expected);
          // The counter was cleared at start, so zero marks the first mismatch.
          if (fail_count == '0) begin
            first_fail_vec_nxt = idx;
            first_fail_sum_nxt = dut_sum;
          end
        end
        // Termination on the all-ones index means idx never wraps.
        if ((&idx) || (mismatch && sof_q)) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (fail_count_nxt == '0);
        end else begin
          state_nxt  = SETTLE;
          idx_nxt    = idx + 1'b1;
          settle_nxt = SETTLE_INIT;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      settle_cnt     <= '0;
      sof_q          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_vec <= '0;
      first_fail_sum <= '0;
      err_mask       <= '0;
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      settle_cnt     <= settle_nxt;
      sof_q          <= sof_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
      fail_count     <= fail_count_nxt;
      first_fail_vec <= first_fail_vec_nxt;
      first_fail_sum <= first_fail_sum_nxt;
      err_mask       <= err_mask_nxt;
    end
  end

`ifdef ADDER_BIST_MISR_EN
  adder_bist_misr u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_run),
    .en        (check_en),
    .data      (MISR_W'(dut_sum)),
    .signature (signature)
  );
`else
  logic unused_misr_ctl;
  assign unused_misr_ctl = start_run ^ check_en;
`endif

endmodule
